// File: rtl/handshake_responder.sv
// Four-phase request/acknowledge responder that queues each accepted word into a
// FIFO drained by a valid/ready stream. Define HANDSHAKE_RESPONDER_SYNC_EN to pass
// i_req through a two-flop synchronizer; otherwise i_req must be synchronous to clk.
module handshake_responder #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_req,
   input  logic [WIDTH-1:0]         i_data,
   output logic                     o_ack,
   output logic                     o_valid,
   output logic [WIDTH-1:0]         o_data,
   input  logic                     i_ready,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {
      IDLE,
      ACK_HIGH
   } state_t;

   state_t             state_q;
   logic               ack_q;
   logic               req_e;
   logic               full;
   logic               push;
   logic               pop;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [WIDTH-1:0]   mem_q [DEPTH];

`ifdef HANDSHAKE_RESPONDER_SYNC_EN
   logic sync1_q, sync2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= i_req;
         sync2_q <= sync1_q;
      end
   end

   assign req_e = sync2_q;
`else
   assign req_e = i_req;
`endif

   // Full is judged on registered occupancy, so a same-cycle pop never frees a slot early.
   assign full = (count_q == CNT_W'(DEPTH));
   assign push = (state_q == IDLE) && req_e && !full;
   assign pop  = (count_q != '0) && i_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (push) begin
                  state_q <= ACK_HIGH;
                  ack_q   <= 1'b1;
               end
            end
            ACK_HIGH: begin
               if (!req_e) begin
                  state_q <= IDLE;
                  ack_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               ack_q   <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately left out of reset; o_valid gates its contents.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= i_data;
   end

   assign o_ack   = ack_q;
   assign o_valid = (count_q != '0);
   assign o_data  = mem_q[rd_ptr_q];
   assign o_count = count_q;

endmodule

// File: tb/tb_handshake_responder.sv
// Directed bench for handshake_responder: scoreboard queue filled at request time,
// drained and compared whenever the stream side pops a word.
module tb_handshake_responder;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
`ifdef HANDSHAKE_RESPONDER_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             i_req;
   logic [WIDTH-1:0] i_data;
   logic             o_ack;
   logic             o_valid;
   logic [WIDTH-1:0] o_data;
   logic             i_ready;
   logic [$clog2(DEPTH):0] o_count;

   int checks = 0;
   int errors = 0;
   int pops   = 0;
   logic [WIDTH-1:0] sb [$];

   handshake_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_req   (i_req),
      .i_data  (i_data),
      .o_ack   (o_ack),
      .o_valid (o_valid),
      .o_data  (o_data),
      .i_ready (i_ready),
      .o_count (o_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; a pop that the edge will perform is scored first.
   task automatic tick();
      logic [WIDTH-1:0] exp;
      if (o_valid === 1'b1 && i_ready === 1'b1) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_underflow: observed pop of 0x%0h expected no data", o_data);
         end
         if (sb.size() != 0) begin
            exp = sb.pop_front();
            check("pop_data", 32'(o_data), 32'(exp));
         end
         pops++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input logic val, input int budget, input string tag);
      for (int i = 0; i < budget; i++) begin
         if (o_ack === val) break;
         tick();
      end
      check(tag, 32'(o_ack), 32'(val));
   endtask

   task automatic handshake(input logic [WIDTH-1:0] d);
      i_req  = 1'b1;
      i_data = d;
      sb.push_back(d);
      wait_ack(1'b1, 40, "hs_ack_rise");
      i_req = 1'b0;
      wait_ack(1'b0, 40, "hs_ack_fall");
   endtask

   task automatic drain();
      i_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (o_count == 0) break;
         tick();
      end
      check("drain_count", 32'(o_count), 32'd0);
      check("drain_sb_empty", 32'(sb.size()), 32'd0);
      i_ready = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      i_req   = 1'b0;
      i_data  = '0;
      i_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_ack", 32'(o_ack), 32'd0);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_count", 32'(o_count), 32'd0);

      // Single transfer with cycle-exact timing
      i_req  = 1'b1;
      i_data = 8'hA5;
      sb.push_back(8'hA5);
      for (int c = 1; c <= LAT; c++) tick();
      check("single_ack_before", 32'(o_ack), 32'd0);
      tick();
      check("single_ack_rise", 32'(o_ack), 32'd1);
      check("single_valid", 32'(o_valid), 32'd1);
      check("single_data", 32'(o_data), 32'hA5);
      tick();
      tick();
      i_req = 1'b0;
      for (int c = 0; c < LAT; c++) tick();
      check("single_ack_held", 32'(o_ack), 32'd1);
      tick();
      check("single_ack_fall", 32'(o_ack), 32'd0);
      drain();

      // Fill to DEPTH, then a stalled fifth request released by one pop
      for (int k = 1; k <= 4; k++) handshake(WIDTH'(k));
      check("fill_count", 32'(o_count), 32'd4);
      i_req  = 1'b1;
      i_data = 8'h05;
      sb.push_back(8'h05);
      repeat (LAT + 5) tick();
      check("stall_ack", 32'(o_ack), 32'd0);
      check("stall_count", 32'(o_count), 32'd4);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check("pop_no_push_ack", 32'(o_ack), 32'd0);
      check("pop_no_push_count", 32'(o_count), 32'd3);
      tick();
      check("refill_ack", 32'(o_ack), 32'd1);
      check("refill_count", 32'(o_count), 32'd4);
      i_req = 1'b0;
      wait_ack(1'b0, 40, "refill_ack_fall");
      drain();

      // Wrap the pointers with the sink always ready
      pops = 0;
      i_ready = 1'b1;
      for (int k = 0; k < 10; k++) handshake(8'h10 + WIDTH'(k));
      drain();
      check("wrap_pops", 32'(pops), 32'd10);

      // Request held high: exactly one push
      i_req  = 1'b1;
      i_data = 8'h77;
      sb.push_back(8'h77);
      repeat (20) tick();
      check("held_count", 32'(o_count), 32'd1);
      check("held_ack", 32'(o_ack), 32'd1);
      i_req = 1'b0;
      wait_ack(1'b0, 40, "held_ack_fall");
      drain();

      // Reset in the middle of a handshake with three words queued
      handshake(8'h31);
      handshake(8'h32);
      i_req  = 1'b1;
      i_data = 8'h33;
      sb.push_back(8'h33);
      wait_ack(1'b1, 40, "mid_ack_rise");
      check("mid_count", 32'(o_count), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_ack", 32'(o_ack), 32'd0);
      check("mid_rst_valid", 32'(o_valid), 32'd0);
      check("mid_rst_count", 32'(o_count), 32'd0);
      sb.delete();
      i_data = 8'h3C;
      sb.push_back(8'h3C);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_ack(1'b1, 40, "post_rst_ack");
      check("post_rst_count", 32'(o_count), 32'd1);
      i_req = 1'b0;
      wait_ack(1'b0, 40, "post_rst_ack_fall");
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
